sync_ptr_chk: RTL and testbench
===============================

Name: sync_ptr_chk

Overview:
- Parametrised single-destination-clock synchronizer for a Gray-coded FIFO pointer, with a configurable number of flop stages.
- Also produces:
  - a registered binary copy of the synchronized pointer;
  - a fill-based valid flag;
  - a Gray-coherence checker that flags any multi-bit step.
- Sits on either side of the async FIFO (read pointer into wclk domain, or write pointer into the read domain) and feeds the full/empty logic.

Parameters:
ADDR_WIDTH, 9, FIFO address bits; pointer width is ADDR_WIDTH+1
SYNC_STAGES, 2, number of synchronizer flops; legal 2..4, elaboration error otherwise
CHK_EN, 1, 1 = Gray-coherence checker present; 0 = gray_err/err_sticky tied 0

Ports:
wclk  input  1  destination-domain clock, all logic on posedge
wrst  input  1  synchronous active-high reset
gptr  input  ADDR_WIDTH+1  Gray pointer from foreign domain (asynchronous to wclk)
clr_err  input  1  clears err_sticky
q_gray  output  ADDR_WIDTH+1  synchronized Gray pointer (last sync stage)
q_bin  output  ADDR_WIDTH+1  binary equivalent of q_gray, registered
valid  output  1  pipeline filled since last reset
gray_err  output  1  one-cycle pulse: q_gray changed by more than one bit
err_sticky  output  1  latched gray_err

Behaviour:
- Clock, reset and reset values:
  - All flops update on posedge wclk only; wrst is sampled synchronously.
  - When wrst=1 at an edge: every sync stage, q_gray, q_bin, fill counter, previous-q_gray register, valid, gray_err and err_sticky become 0.
  - Reset values apply after the first edge with wrst=1.
- Sync chain:
  - stage[0] <= gptr; stage[i] <= stage[i-1]; q_gray = stage[SYNC_STAGES-1].
  - A value stable on gptr before edge k appears on q_gray after edge k+SYNC_STAGES-1, i.e. latency SYNC_STAGES edges.
- Binary conversion:
  - Registered: q_bin <= g2b(q_gray), so q_bin lags q_gray by one edge (SYNC_STAGES+1 total).
  - g2b: b[MSB]=g[MSB]; b[i]=b[i+1]^g[i] for i from MSB-1 down to 0.
- Fill counter and valid:
  - Counter width ceil(log2(SYNC_STAGES+2)).
  - Increments each non-reset edge and saturates at SYNC_STAGES+1.
  - valid=1 when the counter equals SYNC_STAGES+1, i.e. after the (SYNC_STAGES+1)th non-reset edge, and stays 1 until the next reset.
  - Consumers treat q_gray/q_bin as don't-care while valid=0.
- Checker (CHK_EN=1):
  - prev register <= q_gray every edge.
  - d = popcount(q_gray ^ prev).
  - gray_err <= (d>1) && valid. It is registered: it asserts on the edge after the offending q_gray appears and lasts one cycle per offending step.
  - No check while valid=0, so reset-to-live transitions never flag.
  - Wrap-around (e.g. 4'b1000 -> 4'b0000) is a single-bit change: no error.
  - d=0 (pointer idle) and d=1 are legal.
- err_sticky:
  - Set when gray_err is set; stays until clr_err=1 or wrst=1.
  - clr_err and a new error on the same edge: set wins, err_sticky=1.
  - clr_err with no error: err_sticky=0 next edge.
- Reset mid-operation:
  - Outputs return to reset values on the next edge and valid drops.
  - The refill sequence restarts from count 0.
  - A wrst pulse shorter than one cycle is not supported.
- No combinational path from gptr to any output. Every output is a flop, or a flop plus the combinational g2b inside the q_bin register stage.

Test Plan:
- Reset fill (ADDR_WIDTH=3, SYNC_STAGES=2): wrst high 2 edges, then low with gptr=4'b0000 → valid=0 for edges 1-2 after release; valid=1 from edge 3 onward; gray_err=0 throughout.
- Latency: after valid, step gptr 0000→0001 before edge k → q_gray=0001 after edge k+1; q_bin=0001 after edge k+2. Repeat with SYNC_STAGES=4: q_gray after edge k+3.
- Gray count and wrap: drive the Gray sequence 0000,0001,0011,0010,0110,…,1000,0000 one step per 3 cycles → q_bin follows 0,1,2,…,15,0; gray_err never asserts.
- Coherence error: after valid, force gptr 0001→0111 (2-bit step) → one-cycle gray_err=1 one edge after q_gray=0111; err_sticky=1 and held.
- Sticky clear and priority:
  - pulse clr_err with no error → err_sticky=0 next edge;
  - inject a 2-bit step timed so gray_err sets on the same edge as clr_err=1 → err_sticky stays 1.
- Mid-run reset: while valid=1 with q_gray=0110, assert wrst for 1 edge → q_gray=0, q_bin=0, valid=0, err_sticky=0; valid returns 3 edges after release; CHK_EN=0 build shows gray_err=0 under the same 2-bit injection.

Source files
------------

// File: rtl/sync_ptr_chk_if.sv
// Pointer-side bus of the Gray pointer synchronizer: foreign pointer in, synchronized views out.
interface sync_ptr_chk_if #(
  parameter int unsigned ADDR_WIDTH = 9
);
  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] gptr;
  logic          clr_err;
  logic [PW-1:0] q_gray;
  logic [PW-1:0] q_bin;
  logic          valid;
  logic          gray_err;
  logic          err_sticky;

  // Producer of the foreign pointer / consumer of the synchronized views
  modport master (
    output gptr,
    output clr_err,
    input  q_gray,
    input  q_bin,
    input  valid,
    input  gray_err,
    input  err_sticky
  );

  // The synchronizer itself
  modport slave (
    input  gptr,
    input  clr_err,
    output q_gray,
    output q_bin,
    output valid,
    output gray_err,
    output err_sticky
  );
endinterface

// File: rtl/sync_ptr_chk.sv
// Gray FIFO pointer synchronizer into the wclk domain, with a registered binary
// copy, a pipeline-fill valid flag and a Gray-coherence (single-bit step) checker.
module sync_ptr_chk #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          CHK_EN      = 1'b1
) (
  input  logic          wclk,
  input  logic          wrst,
  sync_ptr_chk_if.slave bus
);
  localparam int unsigned   PW       = ADDR_WIDTH + 1;
  localparam int unsigned   CW       = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] FILL_MAX = CW'(SYNC_STAGES + 1);

  // Reject unsupported synchronizer depths at elaboration
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_ptr_chk: SYNC_STAGES must be in 2..4");
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] stage_q [SYNC_STAGES];
  logic [PW-1:0] stage_d [SYNC_STAGES];
  logic [PW-1:0] q_bin_q, q_bin_d;
  logic [PW-1:0] prev_q, prev_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          valid_q, valid_d;
  logic          gray_err_q, gray_err_d;
  logic          err_sticky_q, err_sticky_d;
  logic [PW-1:0] q_gray;

  assign q_gray = stage_q[SYNC_STAGES-1];

  // Synchronizer chain: first stage captures the asynchronous pointer
  always_comb begin
    stage_d[0] = bus.gptr;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Binary copy, fill tracking and coherence checking of the synchronized pointer
  always_comb begin
    q_bin_d      = g2b(q_gray);
    prev_d       = q_gray;
    fill_d       = (fill_q == FILL_MAX) ? fill_q : fill_q + CW'(1);
    valid_d      = (fill_d == FILL_MAX);
    // Checking is gated by valid so the reset-to-live jump never flags
    gray_err_d   = CHK_EN && valid_q && ($countones(q_gray ^ prev_q) > 1);
    // A new error on the same edge as a clear keeps the sticky flag set
    err_sticky_d = CHK_EN && (gray_err_d || (err_sticky_q && !bus.clr_err));
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge wclk) begin
    if (wrst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        stage_q[i] <= '0;
      end
      q_bin_q      <= '0;
      prev_q       <= '0;
      fill_q       <= '0;
      valid_q      <= 1'b0;
      gray_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        stage_q[i] <= stage_d[i];
      end
      q_bin_q      <= q_bin_d;
      prev_q       <= prev_d;
      fill_q       <= fill_d;
      valid_q      <= valid_d;
      gray_err_q   <= gray_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.q_gray     = q_gray;
  assign bus.q_bin      = q_bin_q;
  assign bus.valid      = valid_q;
  assign bus.gray_err   = gray_err_q;
  assign bus.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_sync_ptr_chk.sv
// Bench for sync_ptr_chk: three builds (2 stages, 4 stages, 2 stages without checker)
// driven by one shared stimulus and checked every cycle against a history-based model.
module tb_sync_ptr_chk;
  localparam int HMAX = 1024;

  logic       clk;
  logic       rst_drv;
  logic [3:0] g_drv;
  logic       clr_drv;

  sync_ptr_chk_if #(.ADDR_WIDTH(3)) if_s2 ();
  sync_ptr_chk_if #(.ADDR_WIDTH(3)) if_s4 ();
  sync_ptr_chk_if #(.ADDR_WIDTH(3)) if_nc ();

  assign if_s2.gptr    = g_drv;
  assign if_s2.clr_err = clr_drv;
  assign if_s4.gptr    = g_drv;
  assign if_s4.clr_err = clr_drv;
  assign if_nc.gptr    = g_drv;
  assign if_nc.clr_err = clr_drv;

  sync_ptr_chk #(.ADDR_WIDTH(3), .SYNC_STAGES(2), .CHK_EN(1'b1)) u_s2 (
    .wclk(clk), .wrst(rst_drv), .bus(if_s2));
  sync_ptr_chk #(.ADDR_WIDTH(3), .SYNC_STAGES(4), .CHK_EN(1'b1)) u_s4 (
    .wclk(clk), .wrst(rst_drv), .bus(if_s4));
  sync_ptr_chk #(.ADDR_WIDTH(3), .SYNC_STAGES(2), .CHK_EN(1'b0)) u_nc (
    .wclk(clk), .wrst(rst_drv), .bus(if_nc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[m]: pointer sampled at edge m; sr[m]: consecutive non-reset edges ending at m
  logic [3:0] hist [HMAX];
  int         sr   [HMAX];
  int         e_idx = -1;
  bit         armed = 1'b0;
  bit         st [3];

  function automatic logic [3:0] tb_g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  // Pointer seen at the output after edge m: sampled s-1 edges earlier, 0 while refilling
  function automatic logic [3:0] e_qg(input int s, input int m);
    if (m < 0) return 4'd0;
    if (sr[m] < s) return 4'd0;
    return hist[m-s+1];
  endfunction

  function automatic logic [3:0] e_qb(input int s, input int m);
    if (m < 0) return 4'd0;
    if (sr[m] < s + 1) return 4'd0;
    return tb_g2b(hist[m-s]);
  endfunction

  function automatic logic e_val(input int s, input int m);
    return sr[m] >= s + 1;
  endfunction

  // Error after edge m: valid already held before m and the output moved >1 bit on edge m-1
  function automatic logic e_err(input int s, input bit c, input int m);
    if (!c) return 1'b0;
    if (sr[m] < s + 2) return 1'b0;
    return $countones(e_qg(s, m-1) ^ e_qg(s, m-2)) > 1;
  endfunction

  always @(posedge clk) begin
    if (e_idx < HMAX - 1) e_idx++;
    hist[e_idx] = g_drv;
    if (rst_drv) begin
      sr[e_idx] = 0;
      armed = 1'b1;
    end else begin
      sr[e_idx] = (e_idx > 0) ? sr[e_idx-1] + 1 : 1;
    end
    st[0] = rst_drv ? 1'b0 : (e_err(2, 1'b1, e_idx) | (st[0] & !clr_drv));
    st[1] = rst_drv ? 1'b0 : (e_err(4, 1'b1, e_idx) | (st[1] & !clr_drv));
    st[2] = rst_drv ? 1'b0 : (e_err(2, 1'b0, e_idx) | (st[2] & !clr_drv));
  end

  task automatic cmp_dut(input string tag, input int s, input bit c, input int k,
                         input logic [3:0] qg, input logic [3:0] qb, input logic v,
                         input logic ge, input logic es);
    check({tag, ".q_gray"},     8'(qg), 8'(e_qg(s, e_idx)));
    check({tag, ".q_bin"},      8'(qb), 8'(e_qb(s, e_idx)));
    check({tag, ".valid"},      8'(v),  8'(e_val(s, e_idx)));
    check({tag, ".gray_err"},   8'(ge), 8'(e_err(s, c, e_idx)));
    check({tag, ".err_sticky"}, 8'(es), 8'(st[k]));
  endtask

  // Per-cycle comparison of all three builds against the model
  always @(negedge clk) begin
    if (armed) begin
      cmp_dut("s2", 2, 1'b1, 0, if_s2.q_gray, if_s2.q_bin, if_s2.valid,
              if_s2.gray_err, if_s2.err_sticky);
      cmp_dut("s4", 4, 1'b1, 1, if_s4.q_gray, if_s4.q_bin, if_s4.valid,
              if_s4.gray_err, if_s4.err_sticky);
      cmp_dut("nc", 2, 1'b0, 2, if_nc.q_gray, if_nc.q_bin, if_nc.valid,
              if_nc.gray_err, if_nc.err_sticky);
    end
  end

  // ---------------- directed stimulus ----------------
  // Apply inputs just after a falling edge; returns after the next rising edge has acted
  task automatic drive(input logic [3:0] g, input logic c, input logic r);
    g_drv   = g;
    clr_drv = c;
    rst_drv = r;
    @(negedge clk);
  endtask

  task automatic drive_n(input logic [3:0] g, input int n);
    for (int i = 0; i < n; i++) drive(g, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] gv;
    rst_drv = 1'b1;
    g_drv   = 4'd0;
    clr_drv = 1'b0;
    @(negedge clk);

    // Reset and fill
    drive(4'd0, 1'b0, 1'b1);
    drive(4'd0, 1'b0, 1'b1);
    check("rst.q_gray", 8'(if_s2.q_gray), 8'h0);
    check("rst.valid", 8'(if_s2.valid), 8'h0);
    check("rst.err_sticky", 8'(if_s2.err_sticky), 8'h0);
    drive(4'd0, 1'b0, 1'b0);
    check("fill1.valid", 8'(if_s2.valid), 8'h0);
    drive(4'd0, 1'b0, 1'b0);
    check("fill2.valid", 8'(if_s2.valid), 8'h0);
    drive(4'd0, 1'b0, 1'b0);
    check("fill3.valid", 8'(if_s2.valid), 8'h1);
    drive(4'd0, 1'b0, 1'b0);
    check("fill4.s4.valid", 8'(if_s4.valid), 8'h0);
    drive(4'd0, 1'b0, 1'b0);
    check("fill5.s4.valid", 8'(if_s4.valid), 8'h1);

    // Latency 0000 -> 0001
    drive(4'd1, 1'b0, 1'b0);
    check("lat.k.q_gray", 8'(if_s2.q_gray), 8'h0);
    drive(4'd1, 1'b0, 1'b0);
    check("lat.k1.q_gray", 8'(if_s2.q_gray), 8'h1);
    check("lat.k1.q_bin", 8'(if_s2.q_bin), 8'h0);
    drive(4'd1, 1'b0, 1'b0);
    check("lat.k2.q_bin", 8'(if_s2.q_bin), 8'h1);
    check("lat.k2.s4.q_gray", 8'(if_s4.q_gray), 8'h0);
    drive(4'd1, 1'b0, 1'b0);
    check("lat.k3.s4.q_gray", 8'(if_s4.q_gray), 8'h1);
    drive(4'd1, 1'b0, 1'b0);

    // Full Gray count with wrap, three cycles per step
    for (int i = 2; i <= 16; i++) begin
      gv = 4'(i % 16);
      gv = gv ^ (gv >> 1);
      drive_n(gv, 3);
      check("count.q_bin", 8'(if_s2.q_bin), 8'(i % 16));
      check("count.gray_err", 8'(if_s2.gray_err), 8'h0);
    end
    drive_n(4'd0, 3);

    // Two-bit step 0001 -> 0111
    drive_n(4'd1, 6);
    drive(4'd7, 1'b0, 1'b0);
    drive(4'd7, 1'b0, 1'b0);
    check("coh.q_gray", 8'(if_s2.q_gray), 8'h7);
    check("coh.early.gray_err", 8'(if_s2.gray_err), 8'h0);
    drive(4'd7, 1'b0, 1'b0);
    check("coh.gray_err", 8'(if_s2.gray_err), 8'h1);
    check("coh.err_sticky", 8'(if_s2.err_sticky), 8'h1);
    check("coh.nc.gray_err", 8'(if_nc.gray_err), 8'h0);
    drive(4'd7, 1'b0, 1'b0);
    check("coh.pulse_end", 8'(if_s2.gray_err), 8'h0);
    check("coh.held", 8'(if_s2.err_sticky), 8'h1);
    check("coh.s4.early", 8'(if_s4.gray_err), 8'h0);
    drive(4'd7, 1'b0, 1'b0);
    check("coh.s4.gray_err", 8'(if_s4.gray_err), 8'h1);
    drive_n(4'd7, 2);
    check("coh.held2", 8'(if_s2.err_sticky), 8'h1);
    check("coh.nc.err_sticky", 8'(if_nc.err_sticky), 8'h0);

    // Clear with no pending error
    drive(4'd7, 1'b1, 1'b0);
    check("clr.s2.err_sticky", 8'(if_s2.err_sticky), 8'h0);
    check("clr.s4.err_sticky", 8'(if_s4.err_sticky), 8'h0);
    drive(4'd7, 1'b0, 1'b0);

    // Clear colliding with a new error (0111 -> 0000): set wins
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    check("prio.q_gray", 8'(if_s2.q_gray), 8'h0);
    drive(4'd0, 1'b1, 1'b0);
    check("prio.gray_err", 8'(if_s2.gray_err), 8'h1);
    check("prio.err_sticky", 8'(if_s2.err_sticky), 8'h1);
    drive_n(4'd0, 4);
    check("prio.held", 8'(if_s2.err_sticky), 8'h1);

    // Mid-run reset while showing 0110
    drive_n(4'd2, 4);
    drive_n(4'd6, 5);
    check("mid.pre.q_gray", 8'(if_s2.q_gray), 8'h6);
    check("mid.pre.valid", 8'(if_s2.valid), 8'h1);
    drive(4'd6, 1'b0, 1'b1);
    check("mid.q_gray", 8'(if_s2.q_gray), 8'h0);
    check("mid.q_bin", 8'(if_s2.q_bin), 8'h0);
    check("mid.valid", 8'(if_s2.valid), 8'h0);
    check("mid.err_sticky", 8'(if_s2.err_sticky), 8'h0);
    check("mid.s4.valid", 8'(if_s4.valid), 8'h0);
    drive(4'd6, 1'b0, 1'b0);
    check("refill1.valid", 8'(if_s2.valid), 8'h0);
    drive(4'd6, 1'b0, 1'b0);
    check("refill2.valid", 8'(if_s2.valid), 8'h0);
    drive(4'd6, 1'b0, 1'b0);
    check("refill3.valid", 8'(if_s2.valid), 8'h1);
    check("refill3.q_bin", 8'(if_s2.q_bin), 8'h4);
    drive_n(4'd6, 3);
    check("refill.gray_err", 8'(if_s2.gray_err), 8'h0);

    // Two-bit step 0110 -> 0000 seen by both checker builds
    drive_n(4'd0, 3);
    check("inj2.s2.gray_err", 8'(if_s2.gray_err), 8'h1);
    check("inj2.nc.gray_err", 8'(if_nc.gray_err), 8'h0);
    drive_n(4'd0, 4);
    check("inj2.nc.err_sticky", 8'(if_nc.err_sticky), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
